// File: rtl/nv_nvdla_cdp_rdma_rd_arb_if.sv
// Valid/ready request bus with N lanes and a flat payload; lane i's payload is at [i*PD_W +: PD_W].
// The master drives valid/pd and the slave drives ready.
interface nv_nvdla_cdp_rdma_rd_arb_if #(
    parameter int N    = 1,
    parameter int PD_W = 47
);
    logic [N-1:0]      valid;
    logic [N-1:0]      ready;
    logic [N*PD_W-1:0] pd;

    modport master (output valid, output pd, input ready);
    modport slave (input valid, input pd, output ready);
endinterface

// File: rtl/nv_nvdla_cdp_rdma_rd_arb.sv
// Round-robin arbiter sharing the CDP RDMA read-request port between NREQ requesters,
// with a one-entry registered output stage, credit limiting and a credit-stall counter.
module nv_nvdla_cdp_rdma_rd_arb #(
    parameter int NREQ    = 2,
    parameter int PD_W    = 47,
    parameter int CREDITS = 16
) (
    input  logic                              nvdla_core_clk,
    input  logic                              nvdla_core_rst,
    nv_nvdla_cdp_rdma_rd_arb_if.slave         rq,
    nv_nvdla_cdp_rdma_rd_arb_if.master        mcif,
    output logic [1:0]                        rd_req_src,
    input  logic                              cdp2mcif_rd_cdt_lat_fifo_pop,
    input  logic                              perf_clr,
    output logic [4:0]                        credit_avail,
    output logic [31:0]                       dp2reg_credit_stall,
    output logic                              credit_err
);
    localparam logic [4:0] CRED_MAX = 5'(CREDITS);
    localparam logic [1:0] PTR_RST  = 2'(NREQ - 1);

    logic            out_vld_q;
    logic [PD_W-1:0] out_pd_q;
    logic [1:0]      out_src_q;
    logic [1:0]      rr_ptr_q;
    logic [4:0]      credit_q;
    logic [31:0]     stall_q;
    logic            err_q;

    logic            stage_free;
    logic            can_acc;
    logic            acc;
    logic            starved;
    logic [1:0]      gnt;
    logic [1:0]      cand;
    logic [2:0]      sum3;
    logic [3:0]      vld4;
    logic [31:0]     stall_d;

    // Scan from rr_ptr+1 upwards so the previous winner is considered last.
    always_comb begin
        stage_free = !out_vld_q | mcif.ready[0];
        can_acc    = stage_free & (credit_q != '0) & !nvdla_core_rst;
        vld4       = '0;
        vld4[NREQ-1:0] = rq.valid;
        acc        = 1'b0;
        gnt        = rr_ptr_q;
        sum3       = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum3 = {1'b0, rr_ptr_q} + 3'(k);
            if (sum3 >= 3'(NREQ)) sum3 = sum3 - 3'(NREQ);
            cand = sum3[1:0];
            if (!acc && can_acc && vld4[cand]) begin
                acc = 1'b1;
                gnt = cand;
            end
        end
        rq.ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq.ready[i] = acc && (gnt == 2'(i));
        end
    end

    always_comb begin
        starved = (|rq.valid) & stage_free & (credit_q == '0);
        if (perf_clr) begin
            stall_d = '0;
        end else if (starved && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            out_vld_q <= 1'b0;
            out_pd_q  <= '0;
            out_src_q <= '0;
            rr_ptr_q  <= PTR_RST;
            credit_q  <= CRED_MAX;
            stall_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (acc) begin
                out_vld_q <= 1'b1;
                out_pd_q  <= rq.pd[int'(gnt)*PD_W +: PD_W];
                out_src_q <= gnt;
                rr_ptr_q  <= gnt;
            end else if (mcif.ready[0]) begin
                out_vld_q <= 1'b0;
            end
            // Credits are consumed at stage entry, not at MCIF acceptance.
            unique case ({acc, cdp2mcif_rd_cdt_lat_fifo_pop})
                2'b10: credit_q <= credit_q - 5'd1;
                2'b01: begin
                    if (credit_q == CRED_MAX) err_q <= 1'b1;
                    else credit_q <= credit_q + 5'd1;
                end
                default: ;
            endcase
            stall_q <= stall_d;
        end
    end

    assign mcif.valid          = out_vld_q;
    assign mcif.pd             = out_pd_q;
    assign rd_req_src          = out_src_q;
    assign credit_avail        = credit_q;
    assign dp2reg_credit_stall = stall_q;
    assign credit_err          = err_q;
endmodule

// File: tb/tb_nv_nvdla_cdp_rdma_rd_arb.sv
// Directed bench for the CDP RDMA read arbiter: a per-cycle reference model plus literal
// expectations at the interesting points of each scenario.
module tb_nv_nvdla_cdp_rdma_rd_arb;
    localparam int NREQ    = 2;
    localparam int PD_W    = 47;
    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pop = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  src;
    logic [4:0]  cred;
    logic [31:0] stall;
    logic        err;
    bit          preload = 1'b0;

    int checks = 0;
    int errors = 0;

    nv_nvdla_cdp_rdma_rd_arb_if #(.N(NREQ), .PD_W(PD_W)) rq_if ();
    nv_nvdla_cdp_rdma_rd_arb_if #(.N(1), .PD_W(PD_W))    mc_if ();

    nv_nvdla_cdp_rdma_rd_arb #(.NREQ(NREQ), .PD_W(PD_W), .CREDITS(CREDITS)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .rq                           (rq_if),
        .mcif                         (mc_if),
        .rd_req_src                   (src),
        .cdp2mcif_rd_cdt_lat_fifo_pop (pop),
        .perf_clr                     (clr),
        .credit_avail                 (cred),
        .dp2reg_credit_stall          (stall),
        .credit_err                   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pd(input logic [PD_W-1:0] p0, input logic [PD_W-1:0] p1);
        rq_if.pd = {p1, p0};
    endtask

    // Reference model: state of the output entry, credits and counters as the rules define them.
    bit              m_vld   = 1'b0;
    logic [PD_W-1:0] m_pd    = '0;
    int              m_src   = 0;
    int              m_last  = NREQ - 1;
    int              m_cred  = CREDITS;
    longint          m_stall = 0;
    bit              m_err   = 1'b0;
    logic [NREQ-1:0] m_rdy;
    int              m_g;
    int              m_i;
    bit              m_free;
    bit              m_acc;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_rdy  = '0;
            m_acc  = 1'b0;
            m_g    = 0;
            m_free = !m_vld || mc_if.ready[0];
            if (!rst && m_free && m_cred > 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    m_i = (m_last + k) % NREQ;
                    if (!m_acc && rq_if.valid[m_i]) begin
                        m_acc = 1'b1;
                        m_g   = m_i;
                        m_rdy[m_i] = 1'b1;
                    end
                end
            end
            chk("rq_ready", rq_if.ready, m_rdy);
            chk("req_valid", mc_if.valid, m_vld);
            chk("req_pd", mc_if.pd, m_pd);
            chk("req_src", src, m_src);
            chk("credit_avail", cred, m_cred);
            chk("credit_stall", stall, m_stall);
            chk("credit_err", err, m_err);
            if (rst) begin
                m_vld = 0; m_pd = '0; m_src = 0; m_last = NREQ - 1;
                m_cred = CREDITS; m_stall = 0; m_err = 0;
            end else begin
                if (clr) m_stall = 0;
                else if (|rq_if.valid && m_free && m_cred == 0 && m_stall < 64'hFFFF_FFFF)
                    m_stall = m_stall + 1;
                if (preload) m_stall = 64'hFFFF_FFFE;
                if (m_acc) begin
                    m_vld  = 1;
                    m_pd   = rq_if.pd[m_g*PD_W +: PD_W];
                    m_src  = m_g;
                    m_last = m_g;
                end else if (mc_if.ready[0]) begin
                    m_vld = 0;
                end
                m_cred = m_cred + int'(pop) - int'(m_acc);
                if (m_cred > CREDITS) begin
                    m_cred = CREDITS;
                    m_err  = 1;
                end
            end
        end
    end

    initial begin
        rq_if.valid = '0;
        rq_if.pd    = '0;
        mc_if.ready = 1'b0;
        repeat (2) tick();

        // Round robin with pops balancing accepts.
        rst = 1'b0; rq_if.valid = 2'b11; mc_if.ready = 1'b1; pop = 1'b1;
        set_pd(47'h0A0, 47'h0A1);
        @(negedge clk);
        chk("rr_c0_ready", rq_if.ready, 2'b01);
        chk("rr_c0_valid", mc_if.valid, 1'b0);
        tick(); @(negedge clk);
        chk("rr_c1_ready", rq_if.ready, 2'b10);
        chk("rr_c1_valid", mc_if.valid, 1'b1);
        chk("rr_c1_src", src, 2'd0);
        tick(); @(negedge clk);
        chk("rr_c2_ready", rq_if.ready, 2'b01);
        chk("rr_c2_src", src, 2'd1);
        repeat (3) tick();

        // Credit exhaustion: 4 accepts, then 10 starved cycles.
        tick(); rq_if.valid = 2'b01; pop = 1'b0; set_pd(47'h0B0, 47'h0B1);
        repeat (14) tick();
        @(negedge clk);
        chk("exh_stall10", stall, 32'd10);
        chk("exh_cred0", cred, 5'd0);
        chk("exh_ready0", rq_if.ready, 2'b00);
        tick(); pop = 1'b1;
        @(negedge clk); chk("pop_same_cycle", rq_if.ready, 2'b00);
        tick(); pop = 1'b0;
        @(negedge clk); chk("pop_next_cycle", rq_if.ready, 2'b01);
        tick();
        @(negedge clk); chk("one_accept_only", rq_if.ready, 2'b00);

        // Backpressure with an entry held.
        tick(); rq_if.valid = 2'b00; pop = 1'b1;
        repeat (2) tick();
        tick(); pop = 1'b0; rq_if.valid = 2'b01; mc_if.ready = 1'b0; set_pd(47'h1C0DE, 47'h0);
        tick(); rq_if.valid = 2'b11; set_pd(47'h2C0DE, 47'h3C0DE);
        repeat (4) tick();
        @(negedge clk);
        chk("bp_ready0", rq_if.ready, 2'b00);
        chk("bp_pd_hold", mc_if.pd, 47'h1C0DE);
        chk("bp_src_hold", src, 2'd0);
        tick(); mc_if.ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", rq_if.ready, 2'b10);
        chk("bp_release_valid", mc_if.valid, 1'b1);

        // Simultaneous accept and pop, then credit overflow.
        tick(); rq_if.valid = 2'b00; pop = 1'b1;
        @(negedge clk);
        chk("bp_new_src", src, 2'd1);
        chk("bp_new_pd", mc_if.pd, 47'h3C0DE);
        tick();
        tick(); rq_if.valid = 2'b01; set_pd(47'h0C0, 47'h0C1);
        @(negedge clk); chk("cred3_before", cred, 5'd3);
        tick(); rq_if.valid = 2'b00;
        @(negedge clk); chk("acc_pop_same", cred, 5'd3);
        tick();
        @(negedge clk);
        chk("ovf_pre_err", err, 1'b0);
        chk("ovf_pre_cred", cred, 5'd4);
        tick(); pop = 1'b0;
        @(negedge clk);
        chk("ovf_err", err, 1'b1);
        chk("ovf_cred_hold", cred, 5'd4);
        repeat (3) tick();
        @(negedge clk); chk("err_sticky", err, 1'b1);

        // Reset mid-transfer.
        tick(); rq_if.valid = 2'b01; set_pd(47'h0D0, 47'h0D1);
        tick();
        tick(); rst = 1'b1; rq_if.valid = 2'b00; mc_if.ready = 1'b0;
        @(negedge clk);
        chk("rst_pre_cred", cred, 5'd2);
        chk("rst_pre_valid", mc_if.valid, 1'b1);
        chk("rst_ready_low", rq_if.ready, 2'b00);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_valid0", mc_if.valid, 1'b0);
        chk("rst_cred", cred, 5'd4);
        chk("rst_stall0", stall, 32'd0);
        chk("rst_err0", err, 1'b0);

        // Stall counter saturation and clear.
        tick(); rq_if.valid = 2'b01; mc_if.ready = 1'b1;
        repeat (4) tick();
        #2;
        force dut.stall_d = 32'hFFFF_FFFE;
        preload = 1'b1;
        tick();
        release dut.stall_d;
        preload = 1'b0;
        @(negedge clk); chk("sat_preload", stall, 32'hFFFF_FFFE);
        repeat (3) tick();
        @(negedge clk); chk("stall_sat", stall, 32'hFFFF_FFFF);
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        @(negedge clk); chk("perf_clr", stall, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
